// File: rtl/bh1750_ctrl_if.sv
// Transaction-level handshake between the BH1750 sequencer and its I2C master.
// The sequencer drives request/command; the master answers with done, NACK and read data.
interface bh1750_ctrl_if;
   logic        i2c_req;
   logic        i2c_rw;
   logic [7:0]  i2c_cmd;
   logic        i2c_done;
   logic        i2c_ack_err;
   logic [15:0] i2c_rd_data;

   modport master (
      output i2c_req,
      output i2c_rw,
      output i2c_cmd,
      input  i2c_done,
      input  i2c_ack_err,
      input  i2c_rd_data
   );

   modport slave (
      input  i2c_req,
      input  i2c_rw,
      input  i2c_cmd,
      output i2c_done,
      output i2c_ack_err,
      output i2c_rd_data
   );
endinterface

// File: rtl/bh1750_ctrl.sv
// BH1750 sequencer: power-on, mode select, then periodic 16-bit reads through a
// transaction-level I2C master, with NACK/timeout recovery by re-initialisation.
module bh1750_ctrl #(
   parameter logic [19:0] CNT_PWR_MAX  = 20'd499_999,
   parameter logic [23:0] CNT_MEAS_MAX = 24'd8_999_999,
   parameter logic [19:0] CNT_TO_MAX   = 20'd999_999,
   parameter logic [7:0]  CMD_PWR_ON   = 8'h01,
   parameter logic [7:0]  CMD_MODE     = 8'h10
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   bh1750_ctrl_if.master        i2c,
   output logic [15:0]          lux_raw_o,
   output logic                 lux_valid_o,
   output logic                 err_flag_o
);

   localparam int unsigned CNT_W  = 24;
   localparam int unsigned DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE, PWR_WAIT, PWR_ON, MODE_SET, MEAS_WAIT, READ, UPDATE, ERR_WAIT
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                req_q, req_d;
   logic                rw_q, rw_d;
   logic [7:0]          cmd_q, cmd_d;
   logic [DATA_W-1:0]   lux_raw_q, lux_raw_d;
   logic                valid_q, valid_d;
   logic                err_q, err_d;

   logic                xact_c, done_live_c, done_ok_c, done_err_c;

   // A done only counts in a transaction state and never in the request cycle.
   always_comb begin
      xact_c      = (state_q == PWR_ON) || (state_q == MODE_SET) || (state_q == READ);
      done_live_c = xact_c && i2c.i2c_done && !req_q;
      done_ok_c   = done_live_c && !i2c.i2c_ack_err;
      done_err_c  = (done_live_c && i2c.i2c_ack_err) ||
                    (xact_c && !done_live_c && (cnt_q == CNT_W'(CNT_TO_MAX)));
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      req_d     = 1'b0;
      rw_d      = rw_q;
      cmd_d     = cmd_q;
      lux_raw_d = lux_raw_q;
      valid_d   = 1'b0;
      err_d     = err_q;

      case (state_q)
         IDLE:      state_d = PWR_WAIT;
         PWR_WAIT:  if (cnt_q == CNT_W'(CNT_PWR_MAX)) state_d = PWR_ON;
         PWR_ON: begin
            if (done_ok_c)       state_d = MODE_SET;
            else if (done_err_c) state_d = ERR_WAIT;
         end
         MODE_SET: begin
            if (done_ok_c)       state_d = MEAS_WAIT;
            else if (done_err_c) state_d = ERR_WAIT;
         end
         MEAS_WAIT: if (cnt_q == CNT_MEAS_MAX) state_d = READ;
         READ: begin
            if (done_ok_c) begin
               state_d   = UPDATE;
               lux_raw_d = i2c.i2c_rd_data;
               valid_d   = 1'b1;
               err_d     = 1'b0;
            end else if (done_err_c) begin
               state_d = ERR_WAIT;
            end
         end
         UPDATE:    state_d = MEAS_WAIT;
         ERR_WAIT:  if (cnt_q == CNT_MEAS_MAX) state_d = PWR_ON;
         default:   state_d = IDLE;
      endcase

      // Entry actions: shared counter restarts, request registered for the first cycle.
      if (state_d != state_q) begin
         cnt_d = '0;
         case (state_d)
            PWR_ON: begin
               req_d = 1'b1;
               rw_d  = 1'b0;
               cmd_d = CMD_PWR_ON;
            end
            MODE_SET: begin
               req_d = 1'b1;
               rw_d  = 1'b0;
               cmd_d = CMD_MODE;
            end
            READ: begin
               req_d = 1'b1;
               rw_d  = 1'b1;
               cmd_d = 8'h00;
            end
            ERR_WAIT: err_d = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         rw_q      <= 1'b0;
         cmd_q     <= 8'h00;
         lux_raw_q <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         rw_q      <= rw_d;
         cmd_q     <= cmd_d;
         lux_raw_q <= lux_raw_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign i2c.i2c_req  = req_q;
   assign i2c.i2c_rw   = rw_q;
   assign i2c.i2c_cmd  = cmd_q;
   assign lux_raw_o    = lux_raw_q;
   assign lux_valid_o  = valid_q;
   assign err_flag_o   = err_q;

endmodule
